// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register map, bus
// response codes and sizing constants.
package irq_ctrl_pkg;

  localparam int IRQ_NUM_MAX = 32;
  localparam int ID_W        = 5;

  // Byte offsets of the control registers.
  localparam logic [3:0] REG_PEND   = 4'h0;
  localparam logic [3:0] REG_MASK   = 4'h4;
  localparam logic [3:0] REG_TYPE   = 4'h8;
  localparam logic [3:0] REG_ACTIVE = 4'hC;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_e;

  // Expand the 4-bit byteenable into a 32-bit bit mask.
  function automatic logic [31:0] be_to_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/irq_controller_prio_enc.sv
// Combinational priority encoder: lowest-numbered active request wins.
// id is 0 when no request is active.
module irq_prio_enc
  import irq_ctrl_pkg::*;
#(
  parameter int IRQ_NUM = 8
) (
  input  logic [IRQ_NUM-1:0] req,
  output logic               valid,
  output logic [ID_W-1:0]    id
);

  // Scan from the top down so the lowest index is the last to overwrite id.
  always_comb begin
    valid = |req;
    id    = '0;
    for (int i = IRQ_NUM - 1; i >= 0; i--) begin
      if (req[i]) id = ID_W'(i);
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Interrupt aggregator with an Avalon-MM control slave.
// Latches per-line requests (edge or level), masks them and drives a
// registered CPU interrupt plus the id of the highest-priority line.
// Optional build macro IRQ_SYNC_EN: adds a 2-flop synchronizer on irq_in.
module irq_controller
  import irq_ctrl_pkg::*;
#(
  parameter int IRQ_NUM = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         ctrl_address,
  input  logic               ctrl_read,
  output logic [31:0]        ctrl_readdata,
  output logic [1:0]         ctrl_response,
  input  logic               ctrl_write,
  input  logic [31:0]        ctrl_writedata,
  input  logic [3:0]         ctrl_byteenable,
  output logic               ctrl_waitrequest,
  input  logic [IRQ_NUM-1:0] irq_in,
  output logic               cpu_irq,
  output logic [ID_W-1:0]    cpu_irq_id
);

  // Handshake: the master holds read/write, address and data until it sees
  // waitrequest low at a rising edge. ack goes high for exactly one cycle on
  // the edge after a request appears; read data/response are registered on
  // that same edge, and write side-effects commit on the edge that ends the
  // ack cycle. A request therefore takes two cycles end to end.

  logic [IRQ_NUM-1:0] irq_s;

`ifdef IRQ_SYNC_EN
  logic [IRQ_NUM-1:0] sync1_q, sync1_d;
  logic [IRQ_NUM-1:0] sync2_q, sync2_d;

  // Next state of the two synchronizer stages.
  always_comb begin
    sync1_d = irq_in;
    sync2_d = sync1_q;
  end

  // Two-flop synchronizer for asynchronous peripheral lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign irq_s = sync2_q;
`else
  assign irq_s = irq_in;
`endif

  logic               ack_q, ack_d;
  logic [IRQ_NUM-1:0] pend_q, pend_d;
  logic [IRQ_NUM-1:0] mask_q, mask_d;
  logic [IRQ_NUM-1:0] irq_type_q, irq_type_d;
  logic [IRQ_NUM-1:0] irq_prev_q, irq_prev_d;
  logic               cpu_irq_q, cpu_irq_d;
  logic [ID_W-1:0]    cpu_irq_id_q, cpu_irq_id_d;
  logic [31:0]        readdata_q, readdata_d;
  resp_e              response_q, response_d;

  logic               acc_req;
  logic               addr_ok;
  logic               wr_commit;
  logic [31:0]        be_mask_full;
  logic [IRQ_NUM-1:0] be_mask;
  logic [IRQ_NUM-1:0] wdata_n;
  logic [IRQ_NUM-1:0] pend_clr;
  logic [IRQ_NUM-1:0] pend_rise;
  logic [31:0]        pend_w, mask_w, type_w, active_w;
  logic               enc_valid;
  logic [ID_W-1:0]    enc_id;
  logic               unused_bits;

  assign acc_req      = ctrl_read | ctrl_write;
  assign addr_ok      = (ctrl_address[1:0] == 2'b00);
  assign wr_commit    = ack_q & ctrl_write & addr_ok;
  assign be_mask_full = be_to_mask(ctrl_byteenable);
  assign be_mask      = be_mask_full[IRQ_NUM-1:0];
  assign wdata_n      = ctrl_writedata[IRQ_NUM-1:0];
  assign unused_bits  = ^{ctrl_writedata, be_mask_full};

  irq_prio_enc #(.IRQ_NUM(IRQ_NUM)) u_prio_enc (
    .req   (pend_q & mask_q),
    .valid (enc_valid),
    .id    (enc_id)
  );

  // Zero-extend the IRQ_NUM-wide registers onto the 32-bit read bus.
  always_comb begin
    pend_w                = '0;
    mask_w                = '0;
    type_w                = '0;
    pend_w[IRQ_NUM-1:0]   = pend_q;
    mask_w[IRQ_NUM-1:0]   = mask_q;
    type_w[IRQ_NUM-1:0]   = irq_type_q;
    active_w              = '0;
    active_w[31]          = cpu_irq_q;
    active_w[ID_W-1:0]    = cpu_irq_id_q;
  end

  // Bus handshake and read-data capture on the edge that raises ack.
  always_comb begin
    ack_d      = acc_req & ~ack_q;
    readdata_d = readdata_q;
    response_d = response_q;
    if (acc_req && !ack_q) begin
      readdata_d = '0;
      response_d = RESP_OKAY;
      if (!addr_ok) begin
        response_d = RESP_SLVERR;
      end else if (!ctrl_write) begin
        case (ctrl_address)
          REG_PEND:   readdata_d = pend_w;
          REG_MASK:   readdata_d = mask_w;
          REG_TYPE:   readdata_d = type_w;
          REG_ACTIVE: readdata_d = active_w;
          default:    readdata_d = '0;
        endcase
      end
    end
  end

  // Register writes, pending-latch update and output staging.
  always_comb begin
    mask_d     = mask_q;
    irq_type_d = irq_type_q;
    pend_clr   = '0;
    if (wr_commit && ctrl_address == REG_MASK)
      mask_d = (mask_q & ~be_mask) | (wdata_n & be_mask);
    if (wr_commit && ctrl_address == REG_TYPE)
      irq_type_d = (irq_type_q & ~be_mask) | (wdata_n & be_mask);
    if (wr_commit && ctrl_address == REG_PEND)
      pend_clr = wdata_n & be_mask;
    pend_rise  = irq_s & ~irq_prev_q;
    // Edge lines: a new rising edge beats a same-cycle write-1-clear.
    // Level lines: follow the input, clears are ignored.
    pend_d     = (irq_type_q & ((pend_q & ~pend_clr) | pend_rise)) |
                 (~irq_type_q & irq_s);
    irq_prev_d   = irq_s;
    cpu_irq_d    = enc_valid;
    cpu_irq_id_d = enc_id;
  end

  // State registers; reset drops any in-flight access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q        <= 1'b0;
      pend_q       <= '0;
      mask_q       <= '0;
      irq_type_q   <= '1;
      irq_prev_q   <= '0;
      cpu_irq_q    <= 1'b0;
      cpu_irq_id_q <= '0;
      readdata_q   <= '0;
      response_q   <= RESP_OKAY;
    end else begin
      ack_q        <= ack_d;
      pend_q       <= pend_d;
      mask_q       <= mask_d;
      irq_type_q   <= irq_type_d;
      irq_prev_q   <= irq_prev_d;
      cpu_irq_q    <= cpu_irq_d;
      cpu_irq_id_q <= cpu_irq_id_d;
      readdata_q   <= readdata_d;
      response_q   <= response_d;
    end
  end

  assign ctrl_waitrequest = ~ack_q;
  assign ctrl_readdata    = readdata_q;
  assign ctrl_response    = response_q;
  assign cpu_irq          = cpu_irq_q;
  assign cpu_irq_id       = cpu_irq_id_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed testbench for irq_controller (IRQ_NUM=8, synchronizer disabled).
module tb_irq_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  ctrl_address;
  logic        ctrl_read;
  logic [31:0] ctrl_readdata;
  logic [1:0]  ctrl_response;
  logic        ctrl_write;
  logic [31:0] ctrl_writedata;
  logic [3:0]  ctrl_byteenable;
  logic        ctrl_waitrequest;
  logic [7:0]  irq_in;
  logic        cpu_irq;
  logic [4:0]  cpu_irq_id;

  int checks = 0;
  int fails  = 0;

  // Clock
  always #5 clk = ~clk;

  irq_controller #(.IRQ_NUM(8)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ctrl_address     (ctrl_address),
    .ctrl_read        (ctrl_read),
    .ctrl_readdata    (ctrl_readdata),
    .ctrl_response    (ctrl_response),
    .ctrl_write       (ctrl_write),
    .ctrl_writedata   (ctrl_writedata),
    .ctrl_byteenable  (ctrl_byteenable),
    .ctrl_waitrequest (ctrl_waitrequest),
    .irq_in           (irq_in),
    .cpu_irq          (cpu_irq),
    .cpu_irq_id       (cpu_irq_id)
  );

  // Driver: one Avalon access. irq_or is OR-ed onto irq_in in the cycle
  // whose closing edge commits the write.
  task automatic bus_access(input logic rd, input logic wr, input logic [3:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be,
                            input logic [7:0] irq_or,
                            output logic [31:0] rdata, output logic [1:0] resp,
                            output int waits);
    @(negedge clk);
    ctrl_address    = addr;
    ctrl_read       = rd;
    ctrl_write      = wr;
    ctrl_writedata  = wdata;
    ctrl_byteenable = be;
    rdata = '0;
    resp  = 2'b11;
    waits = 0;
    while (waits < 8) begin
      @(negedge clk);
      waits++;
      if (!ctrl_waitrequest) break;
    end
    checks++;
    if (ctrl_waitrequest) begin
      fails++;
      $display("FAIL bus_timeout addr=%h: waitrequest=%b, required 0", addr, ctrl_waitrequest);
    end else begin
      rdata  = ctrl_readdata;
      resp   = ctrl_response;
      irq_in = irq_in | irq_or;
    end
    @(posedge clk);
    #1;
    ctrl_read  = 1'b0;
    ctrl_write = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] addr, output logic [31:0] rdata,
                          output logic [1:0] resp);
    int w;
    bus_access(1'b1, 1'b0, addr, 32'h0, 4'h0, 8'h00, rdata, resp, w);
  endtask

  task automatic bus_write(input logic [3:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, output logic [1:0] resp);
    logic [31:0] d;
    int w;
    bus_access(1'b0, 1'b1, addr, wdata, be, 8'h00, d, resp, w);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [1:0]  r;
    rst_n = 1'b0;
    ctrl_address = 4'h0; ctrl_read = 1'b0; ctrl_write = 1'b0;
    ctrl_writedata = 32'h0; ctrl_byteenable = 4'h0; irq_in = 8'h00;
    repeat (3) @(negedge clk);
    checks++; if (ctrl_waitrequest !== 1'b1) begin fails++; $display("FAIL reset_waitrequest: got %b expected 1", ctrl_waitrequest); end
    checks++; if (cpu_irq !== 1'b0) begin fails++; $display("FAIL reset_cpu_irq: got %b expected 0", cpu_irq); end
    checks++; if (cpu_irq_id !== 5'd0) begin fails++; $display("FAIL reset_cpu_irq_id: got %0d expected 0", cpu_irq_id); end
    checks++; if (ctrl_readdata !== 32'h0) begin fails++; $display("FAIL reset_readdata: got %h expected 0", ctrl_readdata); end
    checks++; if (ctrl_response !== 2'b00) begin fails++; $display("FAIL reset_response: got %b expected 00", ctrl_response); end
    rst_n = 1'b1;
    bus_read(4'h8, d, r);
    checks++; if (d !== 32'h000000FF) begin fails++; $display("FAIL reset_type: got %h expected 000000ff", d); end
    checks++; if (r !== 2'b00) begin fails++; $display("FAIL reset_type_resp: got %b expected 00", r); end
    bus_read(4'h0, d, r);
    checks++; if (d !== 32'h0) begin fails++; $display("FAIL reset_pend: got %h expected 0", d); end
    bus_read(4'h4, d, r);
    checks++; if (d !== 32'h0) begin fails++; $display("FAIL reset_mask: got %h expected 0", d); end
  endtask

  task automatic test_edge_irq();
    logic [31:0] d;
    logic [1:0]  r;
    bus_write(4'h4, 32'h01, 4'hF, r);
    @(negedge clk); irq_in = 8'h01;
    @(negedge clk); irq_in = 8'h00;
    checks++; if (cpu_irq !== 1'b0) begin fails++; $display("FAIL edge_irq_early: got %b expected 0", cpu_irq); end
    @(negedge clk);
    checks++; if (cpu_irq !== 1'b1) begin fails++; $display("FAIL edge_irq_rise: got %b expected 1", cpu_irq); end
    bus_read(4'h0, d, r);
    checks++; if (d !== 32'h01) begin fails++; $display("FAIL edge_pend: got %h expected 00000001", d); end
    bus_read(4'hC, d, r);
    checks++; if (d !== 32'h80000000) begin fails++; $display("FAIL edge_active: got %h expected 80000000", d); end
    bus_write(4'h0, 32'h01, 4'hF, r);
    @(negedge clk);
    checks++; if (cpu_irq !== 1'b1) begin fails++; $display("FAIL clear_hold: got %b expected 1", cpu_irq); end
    @(negedge clk);
    checks++; if (cpu_irq !== 1'b0) begin fails++; $display("FAIL clear_drop: got %b expected 0", cpu_irq); end
  endtask

  task automatic test_priority();
    logic [1:0] r;
    @(negedge clk); irq_in = 8'h0A;
    @(negedge clk); irq_in = 8'h00;
    @(negedge clk);
    checks++; if (cpu_irq !== 1'b0) begin fails++; $display("FAIL prio_masked: got %b expected 0", cpu_irq); end
    bus_write(4'h4, 32'hFF, 4'hF, r);
    @(negedge clk);
    checks++; if (cpu_irq !== 1'b0) begin fails++; $display("FAIL mask_latency: got %b expected 0", cpu_irq); end
    @(negedge clk);
    checks++; if (cpu_irq !== 1'b1) begin fails++; $display("FAIL mask_enable: got %b expected 1", cpu_irq); end
    checks++; if (cpu_irq_id !== 5'd1) begin fails++; $display("FAIL prio_id1: got %0d expected 1", cpu_irq_id); end
    bus_write(4'h0, 32'h02, 4'hF, r);
    repeat (2) @(negedge clk);
    checks++; if (cpu_irq_id !== 5'd3) begin fails++; $display("FAIL prio_id3: got %0d expected 3", cpu_irq_id); end
    bus_write(4'h0, 32'h08, 4'hF, r);
    repeat (2) @(negedge clk);
    checks++; if (cpu_irq !== 1'b0) begin fails++; $display("FAIL prio_all_clear: got %b expected 0", cpu_irq); end
    checks++; if (cpu_irq_id !== 5'd0) begin fails++; $display("FAIL prio_id_idle: got %0d expected 0", cpu_irq_id); end
  endtask

  task automatic test_level();
    logic [31:0] d;
    logic [1:0]  r;
    bus_write(4'h8, 32'hFB, 4'hF, r);
    irq_in = 8'h04;
    repeat (2) @(negedge clk);
    bus_write(4'h0, 32'h04, 4'hF, r);
    bus_read(4'h0, d, r);
    checks++; if (d !== 32'h04) begin fails++; $display("FAIL level_no_clear: got %h expected 00000004", d); end
    checks++; if (cpu_irq_id !== 5'd2) begin fails++; $display("FAIL level_id: got %0d expected 2", cpu_irq_id); end
    @(negedge clk); irq_in = 8'h00;
    repeat (2) @(negedge clk);
    checks++; if (cpu_irq !== 1'b0) begin fails++; $display("FAIL level_drop_irq: got %b expected 0", cpu_irq); end
    bus_read(4'h0, d, r);
    checks++; if (d !== 32'h0) begin fails++; $display("FAIL level_drop_pend: got %h expected 0", d); end
    bus_write(4'h8, 32'hFF, 4'hF, r);
  endtask

  task automatic test_set_wins();
    logic [31:0] d;
    logic [1:0]  r;
    int w;
    bus_access(1'b0, 1'b1, 4'h0, 32'h20, 4'hF, 8'h20, d, r, w);
    irq_in = 8'h00;
    bus_read(4'h0, d, r);
    checks++; if (d !== 32'h20) begin fails++; $display("FAIL set_wins_pend: got %h expected 00000020", d); end
    bus_read(4'hC, d, r);
    checks++; if (d !== 32'h80000005) begin fails++; $display("FAIL set_wins_active: got %h expected 80000005", d); end
    bus_write(4'h0, 32'h20, 4'hF, r);
    bus_read(4'h0, d, r);
    checks++; if (d !== 32'h0) begin fails++; $display("FAIL set_wins_clear: got %h expected 0", d); end
  endtask

  task automatic test_errors();
    logic [31:0] d;
    logic [1:0]  r;
    int w;
    bus_read(4'h6, d, r);
    checks++; if (r !== 2'b10) begin fails++; $display("FAIL unmapped_read_resp: got %b expected 10", r); end
    checks++; if (d !== 32'h0) begin fails++; $display("FAIL unmapped_read_data: got %h expected 0", d); end
    bus_write(4'h4, 32'h0, 4'hF, r);
    bus_write(4'h4, 32'h0000FFFF, 4'h1, r);
    bus_read(4'h4, d, r);
    checks++; if (d !== 32'hFF) begin fails++; $display("FAIL byteenable_lane0: got %h expected 000000ff", d); end
    bus_write(4'h5, 32'h0, 4'hF, r);
    checks++; if (r !== 2'b10) begin fails++; $display("FAIL unmapped_write_resp: got %b expected 10", r); end
    bus_write(4'h4, 32'h000000AA, 4'h2, r);
    bus_read(4'h4, d, r);
    checks++; if (d !== 32'hFF) begin fails++; $display("FAIL write_no_effect: got %h expected 000000ff", d); end
    bus_access(1'b1, 1'b1, 4'h4, 32'h0F, 4'hF, 8'h00, d, r, w);
    checks++; if (d !== 32'h0) begin fails++; $display("FAIL rdwr_data: got %h expected 0", d); end
    bus_read(4'h4, d, r);
    checks++; if (d !== 32'h0F) begin fails++; $display("FAIL rdwr_as_write: got %h expected 0000000f", d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic [1:0]  r;
    int w1, w2;
    bus_access(1'b1, 1'b0, 4'h8, 32'h0, 4'h0, 8'h00, d, r, w1);
    bus_access(1'b1, 1'b0, 4'h4, 32'h0, 4'h0, 8'h00, d, r, w2);
    checks++; if (w1 !== 1 || w2 !== 1) begin fails++; $display("FAIL b2b_wait: got %0d/%0d expected 1/1", w1, w2); end
    checks++; if (d !== 32'h0F) begin fails++; $display("FAIL b2b_data: got %h expected 0000000f", d); end
    @(negedge clk);
    checks++; if (ctrl_waitrequest !== 1'b1) begin fails++; $display("FAIL b2b_idle_wait: got %b expected 1", ctrl_waitrequest); end
  endtask

  task automatic test_reset_mid_access();
    logic [31:0] d;
    logic [1:0]  r;
    @(negedge clk);
    ctrl_address = 4'h4; ctrl_writedata = 32'hFF; ctrl_byteenable = 4'hF; ctrl_write = 1'b1;
    @(negedge clk);
    checks++; if (ctrl_waitrequest !== 1'b0) begin fails++; $display("FAIL mid_ack: got %b expected 0", ctrl_waitrequest); end
    rst_n = 1'b0;
    #1;
    checks++; if (ctrl_waitrequest !== 1'b1) begin fails++; $display("FAIL mid_reset_wait: got %b expected 1", ctrl_waitrequest); end
    ctrl_write = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    bus_read(4'h4, d, r);
    checks++; if (d !== 32'h0) begin fails++; $display("FAIL mid_reset_mask: got %h expected 0", d); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_edge_irq();
    test_priority();
    test_level();
    test_set_wins();
    test_errors();
    test_back_to_back();
    test_reset_mid_access();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
